// File: rtl/debounce_fsm.sv
// Debouncer and edge detector for an already-synchronised switch level.
// A new level must persist STABLE_CNT+1 consecutive edges before db_level follows it.
module debounce_fsm #(
  parameter int STABLE_CNT = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic busy
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Outputs are assigned from the next state so every one of them is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ZERO;
      cnt_reg   <= '0;
      db_level  <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      case (state_reg)
        ZERO: begin
          if (sw_in) begin
            state_reg <= WAIT1;
            cnt_reg   <= '0;
            busy      <= 1'b1;
          end
        end
        WAIT1: begin
          if (!sw_in) begin
            state_reg <= ZERO;
            busy      <= 1'b0;
          end else if (cnt_reg == LAST_CNT) begin
            state_reg <= ONE;
            db_level  <= 1'b1;
            rise_tick <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        ONE: begin
          if (!sw_in) begin
            state_reg <= WAIT0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
          end
        end
        WAIT0: begin
          if (sw_in) begin
            state_reg <= ONE;
            busy      <= 1'b0;
          end else if (cnt_reg == LAST_CNT) begin
            state_reg <= ZERO;
            db_level  <= 1'b0;
            fall_tick <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg <= ZERO;
          cnt_reg   <= '0;
          db_level  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
